// File: rtl/main_mem_model.sv
// Main-memory slave for the arbiter <-> memory interface: single-transaction FSM
// serving write bursts and fixed-latency tagged read bursts from a byte-lane RAM.

module mem_lane #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

module main_mem_model #(
  parameter int ADDR_BITS   = 28,
  parameter int DATA_BITS   = 128,
  parameter int TAG_BITS    = 5,
  parameter int DATA_CYCLES = 4,
  parameter int DEPTH_LOG2  = 12,
  parameter int LATENCY     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [TAG_BITS-1:0]    mem_resp_tag
);
  localparam int NUM_LANES = DATA_BITS / 8;
  localparam int BEAT_LOG  = $clog2(DATA_CYCLES);
  localparam int LINE_W    = DEPTH_LOG2 - BEAT_LOG;
  localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RRESP} state_t;

  typedef struct packed {
    logic [LINE_W-1:0]   line;
    logic [TAG_BITS-1:0] tag;
  } req_t;

  state_t                           state, state_nxt;
  req_t                             req_q;
  logic [BEAT_LOG-1:0]              beat_q, rd_beat;
  logic [LAT_W-1:0]                 lat_q;
  logic                             req_fire, wr_fire, last_beat;
  logic [DEPTH_LOG2-1:0]            wr_row, rd_row;
  logic [NUM_LANES-1:0][7:0]        rd_lanes;
  logic                             unused_addr;

  assign mem_req_ready      = (state == IDLE);
  assign mem_req_data_ready = (state == WDATA);
  assign mem_resp_valid     = (state == RRESP);

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign wr_fire   = mem_req_data_valid & mem_req_data_ready;
  assign last_beat = (beat_q == BEAT_LOG'(DATA_CYCLES - 1));

  // High and beat-select address bits are intentionally dropped (aliasing).
  assign unused_addr = ^mem_req_addr;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_fire) state_nxt = mem_req_rw ? WDATA : RWAIT;
      WDATA: if (wr_fire && last_beat) state_nxt = IDLE;
      RWAIT: if (lat_q == '0) state_nxt = RRESP;
      RRESP: if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= '0;
      beat_q <= '0;
      lat_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req_fire) begin
          req_q.line <= mem_req_addr[DEPTH_LOG2-1:BEAT_LOG];
          req_q.tag  <= mem_req_tag;
          beat_q     <= '0;
          lat_q      <= LAT_W'(LATENCY - 1);
        end
        WDATA: if (wr_fire) beat_q <= beat_q + 1'b1;
        RWAIT: if (lat_q != '0) lat_q <= lat_q - 1'b1;
        RRESP: beat_q <= beat_q + 1'b1;
        default: ;
      endcase
    end
  end

  // RAM read is registered, so the address runs one beat ahead of the output.
  assign rd_beat = (state == RRESP) ? beat_q + 1'b1 : '0;
  assign rd_row  = {req_q.line, rd_beat};
  assign wr_row  = {req_q.line, beat_q};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_lane #(.ADDR_W(DEPTH_LOG2)) u_lane (
      .clk   (clk),
      .we    (wr_fire & mem_req_data_mask[i]),
      .waddr (wr_row),
      .wdata (mem_req_data_bits[8*i +: 8]),
      .raddr (rd_row),
      .rdata (rd_lanes[i])
    );
  end

  assign mem_resp_data = mem_resp_valid ? rd_lanes : '0;
  assign mem_resp_tag  = mem_resp_valid ? req_q.tag : '0;
endmodule

// File: tb/tb_main_mem_model.sv
// Scoreboard bench for main_mem_model: read requests push expected beats with
// their due cycle; a negedge monitor pops and compares each response beat.

module tb_main_mem_model;
  localparam int LAT = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_rw = 1'b0;
  logic [27:0]  mem_req_addr = '0;
  logic [4:0]   mem_req_tag = '0;
  logic         mem_req_data_valid = 1'b0;
  logic [127:0] mem_req_data_bits = '0;
  logic [15:0]  mem_req_data_mask = '0;
  logic         mem_req_ready, mem_req_data_ready, mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [4:0]   mem_resp_tag;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   tag;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  main_mem_model #(
    .ADDR_BITS(28), .DATA_BITS(128), .TAG_BITS(5),
    .DATA_CYCLES(4), .DEPTH_LOG2(12), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat act=valid data=%h tag=%0d exp=no beat (cycle %0d)",
                 mem_resp_data, mem_resp_tag, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_data", mem_resp_data, mon_e.data);
        chk("resp_tag", 128'(mem_resp_tag), 128'(mon_e.tag));
        chk("resp_cycle", 128'(cyc), 128'(mon_e.due));
      end
    end
  end

  task automatic send_req(input logic rw, input logic [27:0] a, input logic [4:0] t,
                          input bit keep, output int acc);
    int n = 0;
    mem_req_valid = 1'b1;
    mem_req_rw = rw;
    mem_req_addr = a;
    mem_req_tag = t;
    while (mem_req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", 128'(n < 100), 128'(1));
    @(posedge clk); #1;
    acc = cyc;
    if (!keep) mem_req_valid = 1'b0;
  endtask

  task automatic push_read(input int acc, input logic [4:0] t, input logic [127:0] d [4]);
    for (int i = 0; i < 4; i++) exp_q.push_back('{data: d[i], tag: t, due: acc + LAT + i});
  endtask

  task automatic do_read(input logic [27:0] a, input logic [4:0] t, input logic [127:0] d [4]);
    int acc;
    send_req(1'b0, a, t, 1'b0, acc);
    push_read(acc, t, d);
  endtask

  // vpat gives data_valid per cycle, LSB first; beyond plen data_valid stays high.
  task automatic do_write(input logic [27:0] a, input logic [127:0] d [4],
                          input logic [15:0] m [4], input logic [7:0] vpat, input int plen);
    int acc;
    int b = 0;
    int j = 0;
    logic v;
    send_req(1'b1, a, 5'd0, 1'b0, acc);
    while (b < 4 && j < 64) begin
      v = (j < plen) ? vpat[j] : 1'b1;
      mem_req_data_valid = v;
      mem_req_data_bits = d[b];
      mem_req_data_mask = m[b];
      chk("wr_data_ready", 128'(mem_req_data_ready), 128'(1));
      chk("wr_req_ready_low", 128'(mem_req_ready), 128'(0));
      @(posedge clk); #1;
      if (v) b++;
      j++;
    end
    mem_req_data_valid = 1'b0;
    chk("wr_done_req_ready", 128'(mem_req_ready), 128'(1));
    chk("wr_done_data_ready", 128'(mem_req_data_ready), 128'(0));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    logic [127:0] da [4], dz [4], d1 [4], dp [4], db [4];
    logic [15:0]  mf [4], mp [4];
    int acc1, acc2;
    da = '{128'hA0, 128'hA1, 128'hA2, 128'hA3};
    dz = '{128'h0, 128'h0, 128'h0, 128'h0};
    d1 = '{{128{1'b1}}, {128{1'b1}}, {128{1'b1}}, {128{1'b1}}};
    dp = '{128'hFF, 128'h0, 128'h0, 128'h0};
    db = '{128'hB0, 128'hB1, 128'hB2, 128'hB3};
    mf = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    mp = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};

    // reset held two cycles
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_req_ready", 128'(mem_req_ready), 128'(1));
    chk("rst_data_ready", 128'(mem_req_data_ready), 128'(0));
    chk("rst_resp_valid", 128'(mem_resp_valid), 128'(0));
    chk("rst_resp_tag", 128'(mem_resp_tag), 128'(0));
    chk("rst_resp_data", mem_resp_data, 128'(0));

    // full write then read
    do_write(28'h10, da, mf, 8'hFF, 0);
    do_read(28'h10, 5'd5, da);
    drain();

    // partial mask over a zeroed line
    do_write(28'h20, dz, mf, 8'hFF, 0);
    do_write(28'h20, d1, mp, 8'hFF, 0);
    do_read(28'h20, 5'd4, dp);
    drain();

    // write burst with data_valid gaps 1,0,0,1,1,0,1
    do_write(28'h30, db, mf, 8'h59, 7);
    do_read(28'h30, 5'd1, db);
    drain();

    // back-to-back reads with valid held high
    send_req(1'b0, 28'h10, 5'd3, 1'b1, acc1);
    push_read(acc1, 5'd3, da);
    send_req(1'b0, 28'h20, 5'd7, 1'b0, acc2);
    push_read(acc2, 5'd7, dp);
    chk("b2b_accept_cycle", 128'(acc2), 128'(acc1 + LAT + 5));
    drain();

    // out-of-range and beat-select address bits alias onto line 0x10
    do_read(28'h1013, 5'd9, da);
    drain();

    // reset during response, after beat 1 is on the bus
    send_req(1'b0, 28'h30, 5'd2, 1'b0, acc1);
    push_read(acc1, 5'd2, db);
    repeat (LAT + 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_beats_seen", 128'(exp_q.size()), 128'(2));
    exp_q.delete();
    chk("midrst_resp_valid", 128'(mem_resp_valid), 128'(0));
    chk("midrst_req_ready", 128'(mem_req_ready), 128'(1));
    repeat (12) @(posedge clk);
    #1;
    do_read(28'h30, 5'd6, db);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
